// File: rtl/imem_loader.sv
// Streams a framed byte image into instruction memory and releases the CPU reset
// once the frame checksum matches.
//
//   state  | meaning
//   IDLE   | hunting for SYNC_BYTE, other bytes dropped
//   LEN    | next byte is the word count N (0 = 256)
//   DATA   | assembling little-endian words, one write per 4 bytes
//   CHK    | next byte is compared against the running XOR
//   DONE   | image good, CPU released, no more bytes taken
//   ERR    | checksum failed, waiting for SYNC_BYTE to retry
module imem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_we,
    output logic [7:0]  o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_cpu_rst_n,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [8:0]  words_left_q, words_left_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  xor_q, xor_d;
    logic        we_q, we_d;
    logic        accept;

    assign o_ready     = (state_q != S_DONE);
    assign accept      = i_valid && o_ready;
    assign o_we        = we_q;
    assign o_waddr     = waddr_q;
    assign o_wdata     = wdata_q;
    assign o_done      = (state_q == S_DONE);
    assign o_err       = (state_q == S_ERR);
    assign o_cpu_rst_n = (state_q == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            lane_q       <= 2'd0;
            words_left_q <= 9'd0;
            waddr_q      <= 8'd0;
            wdata_q      <= 32'd0;
            xor_q        <= 8'd0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            words_left_q <= words_left_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            xor_q        <= xor_d;
            we_q         <= we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        words_left_d = words_left_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        xor_d        = xor_q;
        we_d         = 1'b0;

        // address advances in the strobe cycle so o_waddr is the written index
        if (we_q) begin
            waddr_d = waddr_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && (i_byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    words_left_d = (i_byte == 8'd0) ? 9'd256 : {1'b0, i_byte};
                    lane_d       = 2'd0;
                    waddr_d      = 8'd0;
                    xor_d        = 8'd0;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    wdata_d[8*lane_q +: 8] = i_byte;
                    xor_d                  = xor_q ^ i_byte;
                    lane_d                 = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d         = 1'b1;
                        words_left_d = words_left_q - 9'd1;
                        if (words_left_q == 9'd1) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (i_byte == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                if (accept && (i_byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are built from word lists, and the expected
// memory writes and end status follow directly from how each frame was built.
module tb_imem_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_byte = 8'd0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        o_we;
    logic [7:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_cpu_rst_n;
    logic        o_done;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] frame_words[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];

    imem_loader #(.SYNC_BYTE(SYNC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_byte      (i_byte),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_we) begin
            got_addr.push_back(o_waddr);
            got_data.push_back(o_wdata);
        end
        if (!i_rst) begin
            check("done_err_exclusive", {o_done, o_err} == 2'b11, 1'b0);
        end
    end

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random 0..3
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        logic rdy;
        int   n;
        if (gap_mode == 1) idle(1);
        else if (gap_mode == 2) idle($urandom_range(0, 3));
        i_byte  = b;
        i_valid = 1'b1;
        rdy     = 1'b0;
        n       = 0;
        while (!rdy && n < 20) begin
            @(negedge i_clk);
            rdy = o_ready;
            @(posedge i_clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        check("byte_accepted", rdy, 1'b1);
    endtask

    function automatic logic [7:0] garbage_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        return b;
    endfunction

    // sends prefix garbage + one frame built from frame_words (n_field 0 = 256 words)
    task automatic run_frame(input logic [7:0] n_field, input bit bad_chk,
                             input int gap_mode, input int n_prefix);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'd0;
        for (int i = 0; i < n_prefix; i++) send_byte(garbage_byte(), gap_mode);
        send_byte(SYNC, gap_mode);
        send_byte(n_field, gap_mode);
        for (int i = 0; i < frame_words.size(); i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap_mode);
                x = x ^ w[8*k +: 8];
            end
            exp_addr.push_back(8'(i));
            exp_data.push_back(w);
        end
        if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
        send_byte(x, gap_mode);
        idle(3);
    endtask

    task automatic verify_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_waddr"}, got_addr[i], exp_addr[i]);
            check({tag, "_wdata"}, got_data[i], exp_data[i]);
        end
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_status(input string tag, input bit done_exp, input bit err_exp);
        check({tag, "_done"}, o_done, done_exp);
        check({tag, "_err"}, o_err, err_exp);
        check({tag, "_cpu_rst_n"}, o_cpu_rst_n, done_exp);
        check({tag, "_ready"}, o_ready, !done_exp);
    endtask

    function automatic void random_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom);
    endfunction

    initial begin
        int  nw;
        bit  bad_chk;
        int  gm;

        do_reset();
        @(negedge i_clk);
        check("reset_we", o_we, 1'b0);
        check_status("reset", 1'b0, 1'b0);
        @(posedge i_clk);
        #1;

        // reference frame
        frame_words = '{32'h12345678, 32'hDEADBEEF};
        run_frame(8'd2, 1'b0, 0, 0);
        verify_writes("basic");
        check_status("basic", 1'b1, 1'b0);

        // bad checksum, then retry without reset
        do_reset();
        run_frame(8'd2, 1'b1, 0, 0);
        verify_writes("badchk");
        check_status("badchk", 1'b0, 1'b1);
        run_frame(8'd2, 1'b0, 0, 2);
        verify_writes("retry");
        check_status("retry", 1'b1, 1'b0);

        // garbage prefix before an N=1 frame
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        random_words(1);
        run_frame(8'd1, 1'b0, 0, 0);
        verify_writes("prefix");
        check_status("prefix", 1'b1, 1'b0);

        // valid toggled every other cycle
        do_reset();
        frame_words = '{32'h12345678, 32'hDEADBEEF};
        run_frame(8'd2, 1'b0, 1, 0);
        verify_writes("gapped");
        check_status("gapped", 1'b1, 1'b0);

        // reset mid-frame, colliding with a byte transfer
        do_reset();
        send_byte(SYNC, 0);
        send_byte(8'h02, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_byte  = 8'h34;
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        idle(6);
        check("abort_no_write", 64'(got_addr.size()), 64'd0);
        check_status("abort", 1'b0, 1'b0);
        frame_words = '{32'h00000001};
        run_frame(8'd1, 1'b0, 0, 0);
        verify_writes("after_abort");
        check_status("after_abort", 1'b1, 1'b0);

        // LEN = 0 means 256 words
        do_reset();
        random_words(256);
        run_frame(8'd0, 1'b0, 0, 0);
        verify_writes("full256");
        check_status("full256", 1'b1, 1'b0);

        // randomized frames, possibly failing then retried
        for (int t = 0; t < 8; t++) begin
            do_reset();
            nw      = $urandom_range(1, 7);
            bad_chk = 1'($urandom);
            gm      = $urandom_range(0, 2);
            random_words(nw);
            run_frame(8'(nw), bad_chk, gm, $urandom_range(0, 3));
            verify_writes("rand_first");
            check_status("rand_first", !bad_chk, bad_chk);
            if (bad_chk) begin
                nw = $urandom_range(1, 7);
                random_words(nw);
                run_frame(8'(nw), 1'b0, gm, $urandom_range(0, 3));
                verify_writes("rand_retry");
                check_status("rand_retry", 1'b1, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
